instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the RISC-V core.
- Owns the program counter and requests instruction words from instruction memory over a req/ready handshake.
- Presents each fetched instruction and its opcode field to the decode/immediate-generation logic.
- Takes the sign-extended immediate and a branch-taken flag back, and computes the next PC as PC+4 or PC+imm.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, number of consecutive un-acknowledged request cycles before a fetch timeout fault.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  memory acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word from memory.
- stall  in  1  downstream not ready; holds the current instruction.
- branch_taken  in  1  redirect to pc+imm; sampled only on consume.
- imm  in  32  sign-extended immediate from decode; bit 0 already 0.
- pc  out  32  PC of the presented instruction.
- instruction  out  32  registered instruction word.
- opcode  out  7  equals instruction[6:0].
- instr_valid  out  1  instruction/opcode/pc are valid.
- fetch_err  out  1  sticky fault flag.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE, pc=RESET_PC, instruction=0, wait_cnt=0.
  - imem_req=0, instr_valid=0, fetch_err=0.
  - Reset during a pending request abandons it; any ready/rdata arriving in that cycle is ignored.
- States: IDLE, REQ, VALID, ERROR. All outputs are decoded from registered state; there is no combinational input-to-output path except that imem_addr follows pc.
- IDLE:
  - All outputs quiet.
  - Unconditionally moves to REQ next cycle, with wait_cnt=0.
- REQ:
  - imem_req=1, instr_valid=0.
  - imem_ready=1 at the edge: instruction<=imem_rdata, wait_cnt<=0, go to VALID. A zero-wait memory therefore spends exactly 1 cycle in REQ.
  - imem_ready=0 and wait_cnt==MAX_WAIT-1: go to ERROR.
  - imem_ready=0 otherwise: wait_cnt++.
  - A ready arriving on the MAX_WAIT-th cycle is accepted; ready wins over timeout.
  - imem_rdata is ignored while imem_ready=0.
- VALID:
  - instr_valid=1, imem_req=0.
  - stall=1: hold state; pc and instruction unchanged. branch_taken and imm are ignored.
  - stall=0, branch_taken=0: pc<=pc+4, go to REQ.
  - stall=0, branch_taken=1, target=pc+imm:
    - target[1:0]==0: pc<=target, go to REQ.
    - otherwise: go to ERROR, pc unchanged.
- ERROR:
  - fetch_err=1, imem_req=0, instr_valid=0.
  - pc and instruction hold their values.
  - Exits only via reset.
- Arithmetic: 32-bit modular add; carries are discarded, so 0xFFFFFFFC+4 wraps to 0x00000000.
- Throughput: 2 cycles per instruction with zero-wait memory (REQ then VALID), plus memory wait cycles and stall cycles.
- Latency: first instr_valid appears 3 cycles after reset deasserts with zero-wait memory (IDLE, REQ, VALID).
- opcode is always instruction[6:0], including in ERROR and after reset (0).

Test Plan:
- Zero-wait memory, mem[0]=0x00500093: after reset, imem_req=1 with addr 0 → next cycle instr_valid=1, instruction=0x00500093, opcode=0x13, pc=0 → next request at addr 0x4.
- 3-cycle memory wait, then stall held 2 cycles:
  - instr_valid rises exactly one cycle after ready.
  - pc and instruction are stable throughout the stall.
  - Next request goes out the cycle after stall drops.
- pc=0x10, branch_taken=1, imm=0xFFFFFFF8, stall=0 → next imem_addr=0x08. Repeat with stall=1 in the same cycle → branch ignored, hold.
- Ready never asserted → fetch_err=1 after 16 REQ cycles, imem_req=0. Separate run with ready on the 16th REQ cycle → accepted, no fault.
- pc=0x20, branch_taken=1, imm=0x6 → fetch_err=1, pc stays 0x20. Then assert reset → all outputs back to reset values, fetch resumes at RESET_PC.
- RESET_PC=0xFFFFFFFC, no branch → second request at addr 0x00000000.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory handshake plus the decode-side
// instruction/branch feedback signals. The fetch unit uses the master modport.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, pc, instruction, opcode, instr_valid, fetch_err,
    input  imem_ready, imem_rdata, stall, branch_taken, imm
  );

  modport slave (
    input  imem_req, imem_addr, pc, instruction, opcode, instr_valid, fetch_err,
    output imem_ready, imem_rdata, stall, branch_taken, imm
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per REQ/VALID round trip and
// redirects on taken branches; any timeout or misaligned target is a sticky fault.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERROR} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [WCW-1:0] r_wait_cnt;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [WCW-1:0] w_wait_next;
  logic [31:0] w_target;

  assign w_target = r_pc + bus.imm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      IDLE: begin
        w_state_next = REQ;
        w_wait_next  = '0;
      end
      REQ: begin
        // Ready on the last allowed cycle still wins over the timeout.
        if (bus.imem_ready) begin
          w_instr_next = bus.imem_rdata;
          w_wait_next  = '0;
          w_state_next = VALID;
        end else if (r_wait_cnt == WCW'(MAX_WAIT - 1)) begin
          w_state_next = ERROR;
        end else begin
          w_wait_next = r_wait_cnt + WCW'(1);
        end
      end
      VALID: begin
        if (!bus.stall) begin
          if (!bus.branch_taken) begin
            w_pc_next    = r_pc + 32'd4;
            w_state_next = REQ;
          end else if (w_target[1:0] == 2'b00) begin
            w_pc_next    = w_target;
            w_state_next = REQ;
          end else begin
            w_state_next = ERROR;
          end
        end
      end
      ERROR: begin
        w_state_next = ERROR;
      end
      default: begin
        w_state_next = ERROR;
      end
    endcase
  end

  assign bus.imem_req    = (r_state == REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instruction = r_instr;
  assign bus.opcode      = r_instr[6:0];
  assign bus.instr_valid = (r_state == VALID);
  assign bus.fetch_err   = (r_state == ERROR);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a transaction-level
// model of the PC/instruction sequence; a second instance covers PC wrap-around.
module tb_instr_fetch_unit;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  instr_fetch_unit_if u_if ();
  instr_fetch_unit_if u_if2 ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(u_if)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(MAX_WAIT)) dut_wrap (
    .clk(clk), .reset(reset2), .bus(u_if2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_error_state(input string tag);
    chk({tag, "_err"}, 32'(u_if.fetch_err), 32'd1);
    chk({tag, "_req"}, 32'(u_if.imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(u_if.instr_valid), 32'd0);
    chk({tag, "_pc"}, u_if.pc, exp_pc);
    chk({tag, "_instr"}, u_if.instruction, exp_instr);
    chk({tag, "_opcode"}, 32'(u_if.opcode), 32'(exp_instr[6:0]));
  endtask

  // Reset issued with ready asserted: the response must be discarded.
  task automatic do_reset();
    reset = 1'b1;
    u_if.imem_ready = 1'b1;
    u_if.imem_rdata = $urandom;
    step();
    u_if.imem_ready = 1'b0;
    exp_pc = 32'h0;
    exp_instr = 32'h0;
    chk("rst_req", 32'(u_if.imem_req), 32'd0);
    chk("rst_valid", 32'(u_if.instr_valid), 32'd0);
    chk("rst_err", 32'(u_if.fetch_err), 32'd0);
    chk("rst_pc", u_if.pc, exp_pc);
    chk("rst_instr", u_if.instruction, 32'h0);
    chk("rst_opcode", 32'(u_if.opcode), 32'd0);
    reset = 1'b0;
    step();
    $display("reset: fetch resumes at %h", exp_pc);
  endtask

  // Entered in REQ; waits >= MAX_WAIT means the memory never answers.
  task automatic fetch(input int waits, output bit faulted);
    logic [31:0] word;
    faulted = 1'b0;
    for (int k = 0; k < waits && k < MAX_WAIT; k++) begin
      chk("req_wait", 32'(u_if.imem_req), 32'd1);
      chk("addr_wait", u_if.imem_addr, exp_pc);
      chk("valid_wait", 32'(u_if.instr_valid), 32'd0);
      u_if.imem_ready = 1'b0;
      u_if.imem_rdata = $urandom;
      step();
    end
    if (waits >= MAX_WAIT) begin
      faulted = 1'b1;
      chk_error_state("timeout");
      $display("fetch pc=%h waits=%0d -> timeout fault", exp_pc, waits);
      return;
    end
    chk("req", 32'(u_if.imem_req), 32'd1);
    chk("addr", u_if.imem_addr, exp_pc);
    word = mem_word(exp_pc);
    u_if.imem_ready = 1'b1;
    u_if.imem_rdata = word;
    step();
    u_if.imem_ready = 1'b0;
    u_if.imem_rdata = $urandom;
    exp_instr = word;
    chk("valid", 32'(u_if.instr_valid), 32'd1);
    chk("instr", u_if.instruction, exp_instr);
    chk("opcode", 32'(u_if.opcode), 32'(exp_instr[6:0]));
    chk("pc", u_if.pc, exp_pc);
    chk("req_off", 32'(u_if.imem_req), 32'd0);
    $display("fetch pc=%h waits=%0d instr=%h", exp_pc, waits, word);
  endtask

  // Entered in VALID; holds for 'stalls' cycles, then consumes with br/imm.
  task automatic consume(input int stalls, input bit br, input logic [31:0] immv, output bit faulted);
    logic [31:0] target;
    faulted = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      u_if.stall = 1'b1;
      u_if.branch_taken = 1'b1;
      u_if.imm = $urandom;
      step();
      chk("stall_valid", 32'(u_if.instr_valid), 32'd1);
      chk("stall_pc", u_if.pc, exp_pc);
      chk("stall_instr", u_if.instruction, exp_instr);
      chk("stall_req", 32'(u_if.imem_req), 32'd0);
    end
    u_if.stall = 1'b0;
    u_if.branch_taken = br;
    u_if.imm = immv;
    step();
    u_if.branch_taken = 1'b0;
    u_if.imm = $urandom;
    target = exp_pc + immv;
    if (br && target[1:0] != 2'b00) begin
      faulted = 1'b1;
      chk_error_state("misalign");
      $display("consume pc=%h br=1 imm=%h -> misaligned fault", exp_pc, immv);
      return;
    end
    exp_pc = br ? target : exp_pc + 32'd4;
    chk("next_req", 32'(u_if.imem_req), 32'd1);
    chk("next_addr", u_if.imem_addr, exp_pc);
    chk("next_valid", 32'(u_if.instr_valid), 32'd0);
    $display("consume stalls=%0d br=%0d imm=%h -> next pc=%h", stalls, br, immv, exp_pc);
  endtask

  task automatic hold_error(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.imem_ready = $urandom_range(0, 1);
      u_if.imem_rdata = $urandom;
      u_if.stall = $urandom_range(0, 1);
      u_if.branch_taken = $urandom_range(0, 1);
      step();
      chk_error_state("err_hold");
    end
    u_if.imem_ready = 1'b0;
    u_if.stall = 1'b0;
    u_if.branch_taken = 1'b0;
  endtask

  initial begin
    bit f;
    int off;
    u_if.imem_ready = 1'b0;
    u_if.imem_rdata = 32'h0;
    u_if.stall = 1'b0;
    u_if.branch_taken = 1'b0;
    u_if.imm = 32'h0;
    u_if2.imem_ready = 1'b1;
    u_if2.imem_rdata = 32'h0000_0013;
    u_if2.stall = 1'b0;
    u_if2.branch_taken = 1'b0;
    u_if2.imm = 32'h0;
    exp_pc = 32'h0;
    exp_instr = 32'h0;
    step();

    // Zero-wait fetch of address 0, then sequential step to 0x4.
    do_reset();
    fetch(0, f);
    consume(0, 1'b0, 32'h0, f);

    // Three wait cycles, then a two-cycle stall.
    fetch(3, f);
    consume(2, 1'b0, 32'h0, f);

    // Walk to pc=0x10 and branch back by 8 after a stall that ignores branch.
    fetch(0, f);
    consume(0, 1'b0, 32'h0, f);
    fetch(0, f);
    consume(0, 1'b0, 32'h0, f);
    fetch(0, f);
    chk("pc_at_0x10", exp_pc, 32'h10);
    consume(1, 1'b1, 32'hFFFF_FFF8, f);
    chk("branch_target", u_if.imem_addr, 32'h08);

    // Randomized traffic with aligned branch offsets.
    for (int n = 0; n < 30; n++) begin
      fetch(int'($urandom_range(0, 4)), f);
      off = int'($urandom_range(0, 64)) - 32;
      consume(int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0), 32'(off * 4), f);
    end

    // Memory never answers: fault after MAX_WAIT request cycles.
    fetch(MAX_WAIT, f);
    chk("timeout_flag", 32'(f), 32'd1);
    hold_error(3);
    do_reset();

    // Ready on the final allowed cycle is accepted.
    fetch(MAX_WAIT - 1, f);
    chk("late_ready_err", 32'(u_if.fetch_err), 32'd0);

    // Misaligned branch target from pc=0x20.
    consume(0, 1'b1, 32'h20, f);
    fetch(0, f);
    chk("pc_at_0x20", u_if.pc, 32'h20);
    consume(1, 1'b1, 32'h6, f);
    hold_error(3);
    do_reset();
    fetch(0, f);
    consume(0, 1'b0, 32'h0, f);

    // Wrap-around instance: RESET_PC=0xFFFFFFFC, zero-wait, no branches.
    step();
    checks++;
    assert (u_if2.pc === 32'hFFFF_FFFC) else begin
      errors++;
      $error("FAIL wrap_rst_pc observed=%h expected=%h", u_if2.pc, 32'hFFFF_FFFC);
    end
    reset2 = 1'b0;
    step();
    chk("wrap_req1", 32'(u_if2.imem_req), 32'd1);
    chk("wrap_addr1", u_if2.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid", 32'(u_if2.instr_valid), 32'd1);
    step();
    chk("wrap_req2", 32'(u_if2.imem_req), 32'd1);
    chk("wrap_addr2", u_if2.imem_addr, 32'h0000_0000);
    $display("wrap: second request at %h", u_if2.imem_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
